// File: rtl/qsearch_ctrl_if.sv
// qsearch_ctrl_if: search control/status and measurement handshake of the Q-search controller.
interface qsearch_ctrl_if #(
    parameter int WIDTH    = 10,
    parameter int MAX_ITER = 32
);
    localparam int CW = $clog2(MAX_ITER + 1);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] desired_q;
    logic             meas_req;
    logic             meas_valid;
    logic [WIDTH-1:0] measured_q;
    logic [WIDTH-1:0] i_ref;
    logic             busy;
    logic             done;
    logic             converged;
    logic             fail;
    logic [CW-1:0]    iter_count;
    modport master (
        output start, abort, desired_q, meas_valid, measured_q,
        input  meas_req, i_ref, busy, done, converged, fail, iter_count
    );
    modport slave (
        input  start, abort, desired_q, meas_valid, measured_q,
        output meas_req, i_ref, busy, done, converged, fail, iter_count
    );
endinterface

// File: rtl/qsearch_ctrl.sv
// qsearch_ctrl: binary search of i_ref for a target Q with settle, measure and evaluate phases.
module qsearch_ctrl #(
    parameter int WIDTH         = 10,
    parameter int MAX_ITER      = 32,
    parameter int TOL           = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input logic           clk,
    input logic           rst,
    qsearch_ctrl_if.slave q
);
    localparam int CW = $clog2(MAX_ITER + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [WIDTH-1:0] TOP = '1;
    typedef enum logic [2:0] {IDLE, APPLY, REQ, EVAL, END} state_t;
    state_t           state;
    logic [WIDTH-1:0] lo, hi, mid, q_tgt, q_meas;
    logic [SW-1:0]    settle;
    logic [CW-1:0]    iter;
    logic             meas_req, busy, done, converged, fail;
    logic [WIDTH:0]   err, sum;
    logic [WIDTH-1:0] lo_n, hi_n, mid_n;
    logic [CW-1:0]    iter_n;
    logic             below, hit, stop;
    // Next bounds are only meaningful when stop is clear; the edge cases that would wrap stop first.
    always_comb begin
        err    = q_meas >= q_tgt ? {1'b0, q_meas} - {1'b0, q_tgt} : {1'b0, q_tgt} - {1'b0, q_meas};
        hit    = err <= (WIDTH + 1)'(TOL);
        below  = q_meas < q_tgt;
        lo_n   = below ? mid + 1'b1 : lo;
        hi_n   = below ? hi : mid - 1'b1;
        sum    = {1'b0, lo_n} + {1'b0, hi_n};
        mid_n  = WIDTH'(sum >> 1);
        iter_n = iter + 1'b1;
        stop   = hit || (below ? mid == TOP : mid == '0) || lo_n > hi_n || iter_n == CW'(MAX_ITER);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lo        <= '0;
            hi        <= '0;
            mid       <= '0;
            q_tgt     <= '0;
            q_meas    <= '0;
            settle    <= '0;
            iter      <= '0;
            meas_req  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            fail      <= 1'b0;
        end else if (busy && q.abort) begin
            state    <= IDLE;
            meas_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, END: if (q.start) begin
                    lo        <= '0;
                    hi        <= TOP;
                    mid       <= TOP >> 1;
                    q_tgt     <= q.desired_q;
                    iter      <= '0;
                    settle    <= '0;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    converged <= 1'b0;
                    fail      <= 1'b0;
                    state     <= APPLY;
                end
                APPLY: if (settle == SW'(SETTLE_CYCLES - 1)) begin
                    meas_req <= 1'b1;
                    state    <= REQ;
                end else begin
                    settle <= settle + 1'b1;
                end
                REQ: if (q.meas_valid) begin
                    q_meas   <= q.measured_q;
                    meas_req <= 1'b0;
                    state    <= EVAL;
                end
                EVAL: begin
                    iter <= iter_n;
                    if (stop) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        converged <= hit;
                        fail      <= !hit;
                        state     <= END;
                    end else begin
                        lo     <= lo_n;
                        hi     <= hi_n;
                        mid    <= mid_n;
                        settle <= '0;
                        state  <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign q.meas_req   = meas_req;
    assign q.i_ref      = mid;
    assign q.busy       = busy;
    assign q.done       = done;
    assign q.converged  = converged;
    assign q.fail       = fail;
    assign q.iter_count = iter;
endmodule

// File: tb/tb_qsearch_ctrl.sv
// tb_qsearch_ctrl: two controllers (MAX_ITER 32 and 3) on a monotonic plant; a scoreboard
// fed by a behavioural binary-search model checks every requested i_ref and every result.
module tb_qsearch_ctrl;
    localparam int W = 10;
    typedef struct {bit conv; int iter; int iref;} res_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [W-1:0] desired_q = '0;
    int gain = 4, vdelay = 1, total = 0, bad = 0;
    bit stray = 1'b0;
    int ma[$], mb[$];
    res_t ra[$], rb[$];
    always #5 clk = ~clk;
    qsearch_ctrl_if #(.WIDTH(W), .MAX_ITER(32)) a();
    qsearch_ctrl_if #(.WIDTH(W), .MAX_ITER(3)) b();
    qsearch_ctrl #(.WIDTH(W), .MAX_ITER(32), .TOL(1), .SETTLE_CYCLES(4)) dut_a (.clk(clk), .rst(rst), .q(a));
    qsearch_ctrl #(.WIDTH(W), .MAX_ITER(3), .TOL(1), .SETTLE_CYCLES(4)) dut_b (.clk(clk), .rst(rst), .q(b));
    assign a.start = start;
    assign b.start = start;
    assign a.abort = abort;
    assign b.abort = abort;
    assign a.desired_q = desired_q;
    assign b.desired_q = desired_q;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Plant: Q = i_ref*gain/16, answered vdelay cycles into each request; garbage Q (and optional stray valids) otherwise.
    int wa = 0, wb = 0;
    always @(negedge clk) begin
        wa = a.meas_req ? wa + 1 : 0;
        a.meas_valid = a.meas_req ? wa >= vdelay : stray && $urandom_range(0, 1) == 1;
        a.measured_q = a.meas_req ? W'(int'(a.i_ref) * gain / 16) : W'($urandom);
        wb = b.meas_req ? wb + 1 : 0;
        b.meas_valid = b.meas_req ? wb >= vdelay : stray && $urandom_range(0, 1) == 1;
        b.measured_q = b.meas_req ? W'(int'(b.i_ref) * gain / 16) : W'($urandom);
    end

    // Reference: plain integer binary search over [0,1023] on the same plant law.
    task automatic model(input int d, input int maxit, input bit sel);
        int lo = 0, hi = 1023, m = 0, qv, n = 0;
        res_t r;
        while (1) begin
            m = (lo + hi) / 2;
            qv = m * gain / 16;
            n++;
            if (sel) mb.push_back(m); else ma.push_back(m);
            r.conv = (qv > d ? qv - d : d - qv) <= 1;
            if (r.conv) break;
            if (qv < d) begin
                if (m == 1023) break;
                lo = m + 1;
            end else begin
                if (m == 0) break;
                hi = m - 1;
            end
            if (lo > hi || n == maxit) break;
        end
        r.iter = n;
        r.iref = m;
        if (sel) rb.push_back(r); else ra.push_back(r);
    endtask

    bit pa_req, pa_done, pb_req, pb_done;
    int ca, cb;
    res_t xa, xb;
    always @(negedge clk) begin
        if (a.meas_req && !pa_req) begin
            chk("a_ref_queued", int'(ma.size() > 0), 1);
            if (ma.size() > 0) ca = ma.pop_front();
            chk("a_ref", int'(a.i_ref), ca);
        end else if (a.meas_req) chk("a_ref_hold", int'(a.i_ref), ca);
        if (a.done && !pa_done) begin
            chk("a_res_queued", int'(ra.size() > 0), 1);
            if (ra.size() > 0) begin
                xa = ra.pop_front();
                chk("a_conv", int'(a.converged), int'(xa.conv));
                chk("a_fail", int'(a.fail), int'(!xa.conv));
                chk("a_iter", int'(a.iter_count), xa.iter);
                chk("a_final_ref", int'(a.i_ref), xa.iref);
            end
        end
        if (b.meas_req && !pb_req) begin
            chk("b_ref_queued", int'(mb.size() > 0), 1);
            if (mb.size() > 0) cb = mb.pop_front();
            chk("b_ref", int'(b.i_ref), cb);
        end else if (b.meas_req) chk("b_ref_hold", int'(b.i_ref), cb);
        if (b.done && !pb_done) begin
            chk("b_res_queued", int'(rb.size() > 0), 1);
            if (rb.size() > 0) begin
                xb = rb.pop_front();
                chk("b_conv", int'(b.converged), int'(xb.conv));
                chk("b_fail", int'(b.fail), int'(!xb.conv));
                chk("b_iter", int'(b.iter_count), xb.iter);
                chk("b_final_ref", int'(b.i_ref), xb.iref);
            end
        end
        pa_req = a.meas_req;
        pa_done = a.done;
        pb_req = b.meas_req;
        pb_done = b.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        ma.delete();
        mb.delete();
        ra.delete();
        rb.delete();
    endtask

    task automatic launch(input int d, input int g, input int vd, input bit st);
        flush();
        gain = g;
        vdelay = vd;
        stray = st;
        desired_q = W'(d);
        model(d, 32, 0);
        model(d, 3, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy_a", int'(a.busy), 1);
        chk("start_busy_b", int'(b.busy), 1);
        chk("start_ref", int'(a.i_ref), 511);
        chk("start_done", int'(a.done), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(a.done && b.done) && n < 3000) begin
            tick();
            n++;
        end
        chk("run_timeout", int'(a.done && b.done), 1);
        @(negedge clk);
        tick();
        chk("a_left", ma.size() + ra.size(), 0);
        chk("b_left", mb.size() + rb.size(), 0);
    endtask

    task automatic wait_rise();
        int n = 0;
        bit p = a.meas_req;
        while (n < 200) begin
            tick();
            n++;
            if (a.meas_req && !p) break;
            p = a.meas_req;
        end
        chk("req_timeout", int'(a.meas_req), 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_iref"}, int'(a.i_ref), 0);
        chk({tag, "_req"}, int'(a.meas_req), 0);
        chk({tag, "_busy"}, int'(a.busy), 0);
        chk({tag, "_done"}, int'(a.done), 0);
        chk({tag, "_conv"}, int'(a.converged), 0);
        chk({tag, "_fail"}, int'(a.fail), 0);
        chk({tag, "_iter"}, int'(a.iter_count), 0);
        chk({tag, "_b_iref"}, int'(b.i_ref), 0);
        chk({tag, "_b_busy"}, int'(b.busy), 0);
    endtask

    initial begin
        #1;
        chk_reset("rst0");
        #20;
        rst = 1'b1;
        tick();
        launch(248, 4, 1, 0);
        wait_done();
        chk("tp1_conv", int'(a.converged), 1);
        chk("tp1_iter", int'(a.iter_count), 5);
        chk("tp1_iref", int'(a.i_ref), 991);
        chk("tp3_fail", int'(b.fail), 1);
        chk("tp3_iter", int'(b.iter_count), 3);
        chk("tp3_iref", int'(b.i_ref), 895);
        launch(300, 4, 1, 0);
        wait_done();
        chk("tp2_fail", int'(a.fail), 1);
        chk("tp2_conv", int'(a.converged), 0);
        chk("tp2_iter", int'(a.iter_count), 11);
        chk("tp2_iref", int'(a.i_ref), 1023);
        launch(248, 4, 7, 1);
        wait_done();
        chk("tp4_iref", int'(a.i_ref), 991);
        chk("tp4_conv", int'(a.converged), 1);
        launch(248, 4, 1, 0);
        wait_rise();
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_ignored", int'(a.busy), 1);
        wait_rise();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(a.busy), 0);
        chk("abort_req", int'(a.meas_req), 0);
        chk("abort_done", int'(a.done), 0);
        chk("abort_iref", int'(a.i_ref), 767);
        chk("abort_iter", int'(a.iter_count), 1);
        chk("abort_b_iref", int'(b.i_ref), 767);
        repeat (3) tick();
        chk("abort_stays_idle", int'(a.busy), 0);
        launch(248, 4, 1, 0);
        wait_done();
        chk("rerun_iref", int'(a.i_ref), 991);
        launch(248, 4, 1, 0);
        wait_rise();
        wait_rise();
        repeat (3) tick();
        chk("pre_rst_iref", int'(a.i_ref), 895);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("rst_mid");
        flush();
        #2;
        rst = 1'b1;
        tick();
        launch(248, 4, 1, 0);
        wait_done();
        chk("post_rst_iref", int'(a.i_ref), 991);
        chk("post_rst_iter", int'(a.iter_count), 5);
        for (int i = 0; i < 8; i++) begin
            launch($urandom_range(0, 1023), $urandom_range(1, 16), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
            wait_done();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
